tdm_audio_decoder: RTL and testbench
====================================

// Module: tdm_audio_decoder
// PURPOSE
//  Parametrised serial-audio receiver: decodes a TDM stream (CHANNELS slots of SLOT_BITS
//  each per frame, MSB first) sampled on sclk, emits one DATA_BITS sample per slot on a
//  valid/ready stream tagged with channel index. Generalises stereo I2S/left-justified
//  decoding to N channels with frame-length checking, lock tracking and overrun detection.
// PARAMETERS
//  CHANNELS   8   slots per frame (2..32; 2 = stereo I2S/LJ)
//  SLOT_BITS  32  bits per slot (8..32)
//  DATA_BITS  24  output sample width; must be <= SLOT_BITS
//  CH_W       $clog2(CHANNELS)  width of o_channel (derived, not overridden)
// PORTS
//  sclk           in   1          bit clock; all logic on posedge
//  reset_n        in   1          asynchronous, active-low reset
//  fsync          in   1          frame sync; active level selects slot 0
//  sdin           in   1          serial data
//  is_i2s         in   1          1: MSB one sclk after fsync edge; 0: MSB coincides with edge
//  fsync_polarity in   1          active level of fsync; static while out of reset
//  o_valid        out  1          sample available
//  o_ready        in   1          sink accepts sample
//  o_channel      out  CH_W       slot index of o_audio
//  o_last         out  1          o_channel == CHANNELS-1
//  o_audio        out  DATA_BITS  sample, top DATA_BITS of slot
//  o_locked       out  1          1 while in RUN
//  o_frame_error  out  1          one-cycle pulse on frame length violation
//  o_overrun      out  1          one-cycle pulse when a sample is dropped
// BEHAVIOUR
//  - Reset: all outputs 0; state HUNT; counters 0. Reset asserted mid-frame aborts at once.
//  - Active edge: fsync sampled at active level where previous sample was inactive.
//  - Frame position p = 0..N-1, N = CHANNELS*SLOT_BITS, counts data bits; p=0 is MSB of
//    slot 0 (same cycle as edge if is_i2s=0, next cycle if is_i2s=1).
//  - HUNT: ignore sdin, no samples; active edge -> RUN, p starts at 0 as above.
//  - RUN: slot = p / SLOT_BITS; shift sdin MSB-first; on last bit of slot, sample complete.
//  - Sample complete: next cycle o_audio = slot[SLOT_BITS-1 -: DATA_BITS] (LSBs truncated),
//    o_channel = slot, o_last set for last slot, o_valid = 1 (latency 1 sclk after LSB).
//  - Handshake: payload stable while o_valid && !o_ready; transfer when both high; o_valid
//    drops next cycle unless a new sample completes that same cycle (then it loads, no gap).
//  - Overrun: sample completes while o_valid && !o_ready -> new sample dropped, held one
//    kept, o_overrun pulses 1 cycle.
//  - Early edge (active edge with p != expected p=0 point): o_frame_error pulse, partial slot
//    discarded, edge taken as new frame start, stay RUN.
//  - Missing edge (p wraps N-1 -> 0 with no edge at expected point): o_frame_error pulse,
//    -> HUNT, o_locked 0; slot completed at N-1 still delivered.
//  - Error never clears a pending o_valid sample.
//  - is_i2s / fsync_polarity changes only under reset; otherwise undefined.
// TESTING (CHANNELS=4, SLOT_BITS=32, DATA_BITS=24 unless noted)
//  1 is_i2s=0, slots 0x11223344,0x55667788,0x99AABBCC,0xDDEEFF00, o_ready=1 -> o_audio
//    0x112233,0x556677,0x99AABB,0xDDEEFF, ch 0..3, o_last only on ch3, o_locked after edge.
//  2 Same data, is_i2s=1 (data delayed one sclk) -> identical output sequence, 2 frames.
//  3 o_ready=0 across slots 0 and 1 -> ch0 held stable, ch1 dropped, one o_overrun pulse;
//    o_ready=1 in the cycle ch2 completes -> ch0 transfers, ch2 loads without gap.
//  4 Early fsync edge at p=100 -> one o_frame_error pulse, o_locked stays 1, next frame
//    decodes all 4 slots correctly.
//  5 fsync held inactive after frame 1 -> o_frame_error pulse at wrap, o_locked=0, no
//    o_valid until next edge; relock decodes normally.
//  6 reset_n low mid-slot 2 (no sclk edge) -> all outputs 0 immediately; CHANNELS=2,
//    SLOT_BITS=16, DATA_BITS=16 I2S stereo run decodes 0xA5A5/0x5A5A on ch0/ch1.

Source files
------------

// File: rtl/tdm_audio_decoder.sv
// tdm_audio_decoder: TDM serial-audio receiver with frame lock tracking, emitting one
// truncated sample per slot on a valid/ready stream tagged with its channel index.
module tdm_audio_decoder #(
  parameter int CHANNELS  = 8,
  parameter int SLOT_BITS = 32,
  parameter int DATA_BITS = 24
) (
  input  logic                        sclk,
  input  logic                        reset_n,
  input  logic                        fsync,
  input  logic                        sdin,
  input  logic                        is_i2s,
  input  logic                        fsync_polarity,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [$clog2(CHANNELS)-1:0] o_channel,
  output logic                        o_last,
  output logic [DATA_BITS-1:0]        o_audio,
  output logic                        o_locked,
  output logic                        o_frame_error,
  output logic                        o_overrun
);
  localparam int CH_W = $clog2(CHANNELS);
  localparam int BW   = $clog2(SLOT_BITS);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(SLOT_BITS - 1);
  localparam logic [CH_W-1:0] SLOT_LAST = CH_W'(CHANNELS - 1);

  typedef enum logic {HUNT, RUN} state_t;

  state_t                state_q, state_d;
  logic                  fs_q;
  logic [BW-1:0]         bit_q, bit_d, cur_bit;
  logic [CH_W-1:0]       slot_q, slot_d, cur_slot;
  logic [DATA_BITS-1:0]  sh_q, sh_d, word;
  logic                  valid_q, valid_d, last_q, last_d, err_q, err_d, ovr_q, ovr_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [DATA_BITS-1:0]  aud_q, aud_d;
  logic                  fs_edge, at_exp, restart, take, done;

  assign fs_edge = (fsync == fsync_polarity) && !fs_q;
  // The frame edge is due on the MSB of slot 0 (LJ) or on the LSB of the last slot (I2S)
  assign at_exp  = is_i2s ? (slot_q == SLOT_LAST && bit_q == BIT_LAST)
                          : (slot_q == '0 && bit_q == '0);

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    restart = 1'b0;
    take    = 1'b0;
    if (state_q == HUNT) begin
      state_d = fs_edge ? RUN : HUNT;
      restart = fs_edge;
      take    = fs_edge && !is_i2s;
    end else if (fs_edge && !at_exp) begin
      err_d   = 1'b1;
      restart = 1'b1;
      take    = !is_i2s;
    end else if (!fs_edge && at_exp) begin
      err_d   = 1'b1;
      state_d = HUNT;
      take    = is_i2s;
    end else begin
      take    = 1'b1;
    end
  end

  assign cur_bit  = restart ? '0 : bit_q;
  assign cur_slot = restart ? '0 : slot_q;
  assign done     = take && cur_bit == BIT_LAST;
  assign bit_d    = take ? (cur_bit == BIT_LAST ? '0 : cur_bit + 1'b1) : cur_bit;
  assign slot_d   = done ? (cur_slot == SLOT_LAST ? '0 : cur_slot + 1'b1) : cur_slot;
  // Only the top DATA_BITS of a slot are kept; the rest of the slot just passes by
  assign sh_d     = (take && int'(cur_bit) < DATA_BITS) ? {sh_q[DATA_BITS-2:0], sdin} : sh_q;
  assign word     = (DATA_BITS == SLOT_BITS) ? {sh_q[DATA_BITS-2:0], sdin} : sh_q;

  always_comb begin
    valid_d = valid_q;
    ch_d    = ch_q;
    aud_d   = aud_q;
    last_d  = last_q;
    ovr_d   = done && valid_q && !o_ready;
    if (done && !ovr_d) begin
      valid_d = 1'b1;
      ch_d    = cur_slot;
      aud_d   = word;
      last_d  = cur_slot == SLOT_LAST;
    end else if (!done && valid_q && o_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
      fs_q    <= 1'b0;
      bit_q   <= '0;
      slot_q  <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      aud_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fs_q    <= fsync == fsync_polarity;
      bit_q   <= bit_d;
      slot_q  <= slot_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      aud_q   <= aud_d;
      last_q  <= last_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_channel     = ch_q;
  assign o_last        = last_q;
  assign o_audio       = aud_q;
  assign o_locked      = state_q == RUN;
  assign o_frame_error = err_q;
  assign o_overrun     = ovr_q;
endmodule

// File: tb/tb_tdm_audio_decoder.sv
// tb_tdm_audio_decoder: randomized and directed stimulus for the TDM decoder, checked
// each sclk against a frame-position reference model.
module tb_tdm_audio_decoder;
  localparam int CH = 4, SB = 32, N = CH * SB;

  logic sclk = 0, reset_n = 0, fsync = 0, sdin = 0, is_i2s = 0, fsync_polarity = 1, o_ready = 1;
  logic o_valid, o_last, o_locked, o_frame_error, o_overrun;
  logic [1:0] o_channel;
  logic [23:0] o_audio;
  logic s_fsync = 1, s_sdin = 0, s_is_i2s = 1, s_pol = 0, s_ready = 1;
  logic s_valid, s_last, s_locked, s_ferr, s_ovr;
  logic [0:0] s_channel;
  logic [15:0] s_audio;

  tdm_audio_decoder #(.CHANNELS(4), .SLOT_BITS(32), .DATA_BITS(24)) dut (
    .sclk(sclk), .reset_n(reset_n), .fsync(fsync), .sdin(sdin), .is_i2s(is_i2s),
    .fsync_polarity(fsync_polarity), .o_valid(o_valid), .o_ready(o_ready),
    .o_channel(o_channel), .o_last(o_last), .o_audio(o_audio), .o_locked(o_locked),
    .o_frame_error(o_frame_error), .o_overrun(o_overrun));

  tdm_audio_decoder #(.CHANNELS(2), .SLOT_BITS(16), .DATA_BITS(16)) dut_st (
    .sclk(sclk), .reset_n(reset_n), .fsync(s_fsync), .sdin(s_sdin), .is_i2s(s_is_i2s),
    .fsync_polarity(s_pol), .o_valid(s_valid), .o_ready(s_ready),
    .o_channel(s_channel), .o_last(s_last), .o_audio(s_audio), .o_locked(s_locked),
    .o_frame_error(s_ferr), .o_overrun(s_ovr));

  always #5 sclk = ~sclk;

  int n_chk = 0, n_err = 0, n_fe = 0, n_ov = 0, rdy_cfg = 0;
  bit m_i2s, m_prev, m_run, m_valid, m_last, m_fe, m_ov;
  int m_p, m_ch;
  logic [31:0] m_acc;
  logic [23:0] m_aud;
  bit fsq[$], bq[$], rq[$];
  logic [31:0] xq[$];
  logic [31:0] A [4] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_run = 0; m_valid = 0; m_last = 0; m_fe = 0; m_ov = 0;
    m_p = 0; m_ch = 0; m_acc = 0; m_aud = 0;
  endtask

  // Frame position p counts data bits of the frame; p=0 is the MSB of slot 0
  task automatic model_step(input bit a, input bit d, input bit r);
    bit e, take, done;
    int slot, expp;
    e = a && !m_prev;
    m_prev = a;
    take = 0; done = 0; slot = 0; m_fe = 0; m_ov = 0;
    expp = m_i2s ? N - 1 : 0;
    if (!m_run) begin
      if (e) begin m_run = 1; m_p = 0; take = !m_i2s; end
    end else if (e && m_p != expp) begin
      m_fe = 1; m_p = 0; take = !m_i2s;
    end else if (!e && m_p == expp) begin
      m_fe = 1; m_run = 0; take = m_i2s;
    end else take = 1;
    if (take) begin
      m_acc = {m_acc[30:0], d};
      if (m_p % SB == SB - 1) begin done = 1; slot = m_p / SB; end
      m_p = (m_p + 1) % N;
    end
    if (done) begin
      if (m_valid && !r) m_ov = 1;
      else begin m_valid = 1; m_ch = slot; m_aud = m_acc[31:8]; m_last = slot == CH - 1; end
    end else if (m_valid && r) m_valid = 0;
  endtask

  task automatic step(input bit a, input bit d, input bit r);
    @(negedge sclk);
    chk("valid", o_valid, m_valid);
    chk("channel", o_channel, m_ch);
    chk("audio", o_audio, m_aud);
    chk("last", o_last, m_last);
    chk("locked", o_locked, m_run);
    chk("frame_error", o_frame_error, m_fe);
    chk("overrun", o_overrun, m_ov);
    n_fe += o_frame_error;
    n_ov += o_overrun;
    if (o_valid && r) xq.push_back({5'b0, o_last, o_channel, o_audio});
    fsync = a ? fsync_polarity : !fsync_polarity;
    sdin = d;
    o_ready = r;
    if (reset_n) model_step(a, d, r);
  endtask

  task automatic do_reset(input bit i2s, input bit pol);
    @(negedge sclk);
    reset_n = 0;
    m_i2s = i2s; is_i2s = i2s; fsync_polarity = pol; fsync = !pol; sdin = 0; o_ready = 1;
    model_reset();
    repeat (3) step(0, 0, 1);
    reset_n = 1;
    n_fe = 0; n_ov = 0; xq.delete();
  endtask

  function automatic bit next_rdy();
    return rdy_cfg == 0 ? 1'b1 : rdy_cfg == 2 ? 1'b0 : ($urandom % 4 != 0);
  endfunction

  task automatic add_frame(input logic [31:0] w0, w1, w2, w3, input int nbits);
    logic [127:0] f;
    f = {w0, w1, w2, w3};
    for (int p = 0; p < nbits; p++) begin
      fsq.push_back(p < SB); bq.push_back(f[127-p]); rq.push_back(next_rdy());
    end
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      fsq.push_back(0); bq.push_back(1'($urandom)); rq.push_back(next_rdy());
    end
  endtask

  // In I2S mode the data stream lags the frame sync by one sclk
  task automatic play();
    bit pb;
    pb = 0;
    for (int i = 0; i < fsq.size(); i++) begin
      step(fsq[i], m_i2s ? pb : bq[i], rq[i]);
      pb = bq[i];
    end
    fsq.delete(); bq.delete(); rq.delete();
  endtask

  function automatic logic [31:0] exp_x(input int ch);
    logic [31:0] w;
    w = A[ch];
    return {5'b0, ch == CH - 1, 2'(ch), w[31:8]};
  endfunction

  task automatic chk_x(input string tag, input int idx, input int ch);
    chk(tag, idx < xq.size() ? xq[idx] : 32'hxxxxxxxx, exp_x(ch));
  endtask

  initial begin
    bit sfs[$], sb[$];
    logic [31:0] sw, sx[$];
    bit pb;
    // 1: left-justified, always ready
    do_reset(0, 1);
    add_idle(4); add_frame(A[0], A[1], A[2], A[3], N); add_frame(A[0], A[1], A[2], A[3], N); add_idle(40);
    play();
    chk("s1_count", xq.size(), 8);
    for (int i = 0; i < 8; i++) chk_x("s1_xfer", i, i % 4);
    chk("s1_ferr", n_fe, 1);
    // 2: I2S, inverted sync polarity, same data
    do_reset(1, 0);
    add_idle(5); add_frame(A[0], A[1], A[2], A[3], N); add_frame(A[0], A[1], A[2], A[3], N); add_idle(40);
    play();
    chk("s2_count", xq.size(), 8);
    for (int i = 0; i < 8; i++) chk_x("s2_xfer", i, i % 4);
    chk("s2_ferr", n_fe, 1);
    // 3: sink stalls over slots 0 and 1, ready again as slot 2 completes
    do_reset(0, 1);
    add_idle(4); add_frame(A[0], A[1], A[2], A[3], N); add_idle(40);
    for (int i = 0; i < rq.size(); i++) rq[i] = i >= 4 + 3 * SB - 1;
    play();
    chk("s3_count", xq.size(), 3);
    chk_x("s3_x0", 0, 0); chk_x("s3_x1", 1, 2); chk_x("s3_x2", 2, 3);
    chk("s3_ovr", n_ov, 1);
    // 4: early edge at p=100
    do_reset(0, 1);
    add_idle(4); add_frame(A[0], A[1], A[2], A[3], N); add_frame(A[0], A[1], A[2], A[3], 100);
    add_frame(A[0], A[1], A[2], A[3], N); add_idle(40);
    play();
    chk("s4_count", xq.size(), 11);
    for (int i = 0; i < 4; i++) chk_x("s4_next_frame", 7 + i, i);
    chk("s4_ferr", n_fe, 2);
    // 5: missing edge, then relock
    do_reset(0, 1);
    add_idle(4); add_frame(A[0], A[1], A[2], A[3], N); add_idle(50);
    play();
    chk("s5_unlocked", o_locked, 0);
    chk("s5_ferr", n_fe, 1);
    add_frame(A[0], A[1], A[2], A[3], N); add_idle(20);
    play();
    chk("s5_count", xq.size(), 8);
    for (int i = 0; i < 8; i++) chk_x("s5_xfer", i, i % 4);
    chk("s5_ferr2", n_fe, 2);
    // randomized frames, lengths, modes and backpressure
    for (int r = 0; r < 6; r++) begin
      do_reset(1'($urandom), 1'($urandom));
      rdy_cfg = 1;
      add_idle(3 + $urandom % 5);
      for (int f = 0; f < 4; f++)
        add_frame($urandom, $urandom, $urandom, $urandom, ($urandom % 5 == 0) ? 40 + $urandom % 88 : N);
      add_idle(40);
      play();
      rdy_cfg = 0;
    end
    // 6: asynchronous reset mid slot 2 with a sample pending
    do_reset(0, 1);
    rdy_cfg = 2;
    add_idle(4); add_frame(A[0], A[1], A[2], A[3], 84);
    play();
    rdy_cfg = 0;
    chk("s6_pre_valid", o_valid, 1);
    #2 reset_n = 0;
    #1;
    chk("s6_rst_valid", o_valid, 0);
    chk("s6_rst_channel", o_channel, 0);
    chk("s6_rst_audio", o_audio, 0);
    chk("s6_rst_last", o_last, 0);
    chk("s6_rst_locked", o_locked, 0);
    chk("s6_rst_ferr", o_frame_error, 0);
    chk("s6_rst_ovr", o_overrun, 0);
    model_reset();
    do_reset(0, 1);
    sw = 32'hA5A55A5A;
    for (int i = 0; i < 4; i++) begin sfs.push_back(0); sb.push_back(0); end
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 32; p++) begin sfs.push_back(p < 16); sb.push_back(sw[31-p]); end
    for (int i = 0; i < 10; i++) begin sfs.push_back(0); sb.push_back(0); end
    pb = 0;
    for (int i = 0; i < sfs.size(); i++) begin
      step(0, 1'($urandom), 1);
      if (s_valid && s_ready) sx.push_back({14'b0, s_last, s_channel, s_audio});
      s_fsync = !sfs[i];
      s_sdin = pb;
      pb = sb[i];
    end
    chk("s6_st_count", sx.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("s6_st_xfer", i < sx.size() ? sx[i] : 32'hxxxxxxxx, i % 2 == 0 ? 32'h0000A5A5 : 32'h00035A5A);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
